// File: rtl/i2c_target_pkg.sv
`timescale 1ns/1ps
// Shared FSM state type and bus constants for the I2C target register file.
// The optional line glitch filter (I2C_TARGET_GLITCH_FILTER_EN) uses filter_len.
package i2c_target_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } i2c_state_e;

  localparam logic I2cAck  = 1'b0;
  localparam logic I2cNack = 1'b1;

  localparam int unsigned FilterLen = 3;

endpackage

// File: rtl/i2c_target_line_sync.sv
`timescale 1ns/1ps
// One bus line: 2-flop synchronizer, optional glitch filter, rise/fall detect.
// Define I2C_TARGET_GLITCH_FILTER_EN to require FilterLen stable samples per change.
module i2c_target_line_sync
  import i2c_target_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic level;
  logic prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int CntW = $clog2(FilterLen + 1);

  logic            filt_q;
  logic [CntW-1:0] cnt_q;

  // A new level is taken only once it has been seen on FilterLen consecutive clocks.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else if (sync2_q == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CntW'(FilterLen - 1)) begin
      filt_q <= sync2_q;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level;
    end
  end

  assign level_o = level;
  assign rise_o  = level & ~prev_q;
  assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/i2c_target_regfile.sv
`timescale 1ns/1ps
// I2C target exposing NumRegs 8-bit registers behind an auto-incrementing pointer.
// Build option: I2C_TARGET_GLITCH_FILTER_EN enables the SCL/SDA glitch filter.
module i2c_target_regfile
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TargetAddr = 7'h50,
  parameter int          NumRegs    = 16,
  localparam int         PtrW       = $clog2(NumRegs)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i2c_scl_i,
  input  logic                 i2c_sda_i,
  output logic                 i2c_sda_o,
  output logic                 i2c_sda_en_o,
  output logic [NumRegs*8-1:0] regs_o,
  output logic                 wr_pulse_o,
  output logic [PtrW-1:0]      wr_idx_o
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_target_line_sync u_scl_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .line_i  (i2c_scl_i),
    .level_o (scl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_target_line_sync u_sda_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .line_i  (i2c_sda_i),
    .level_o (sda),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  i2c_state_e      state_q;
  logic [3:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic [7:0]      tx_q;
  logic [PtrW-1:0] ptr_q;
  logic            rw_q;
  logic            sda_en_q;
  logic [7:0]      regs_q [NumRegs];

  logic            start_det, stop_det, byte_done, wr_fire;
  logic [7:0]      rx_byte;
  logic [PtrW-1:0] ptr_inc;

  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;
  assign byte_done = (bit_cnt_q == 4'd8);
  assign rx_byte   = {shift_q[6:0], sda};
  assign ptr_inc   = ptr_q + 1'b1;
  assign wr_fire   = (state_q == WR_DATA) && scl_rise && (bit_cnt_q == 4'd7) &&
                     !start_det && !stop_det;

  // START/STOP override every state; otherwise bits move on synchronized SCL edges.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      sda_en_q  <= 1'b0;
    end else if (start_det) begin
      state_q   <= ADDR;
      bit_cnt_q <= '0;
      sda_en_q  <= 1'b0;
    end else if (stop_det) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sda_en_q  <= 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WR_DATA: begin
          if (scl_rise && !byte_done) begin
            shift_q   <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (state_q == PTR && bit_cnt_q == 4'd7) ptr_q <= rx_byte[PtrW-1:0];
            if (wr_fire) ptr_q <= ptr_inc;
          end else if (scl_fall && byte_done) begin
            bit_cnt_q <= '0;
            if (state_q != ADDR) begin
              sda_en_q <= 1'b1;
              state_q  <= WR_ACK;
            end else if (shift_q[7:1] == TargetAddr) begin
              rw_q     <= shift_q[0];
              sda_en_q <= 1'b1;
              state_q  <= ADDR_ACK;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              sda_en_q <= ~regs_q[ptr_q][7];
              tx_q     <= {regs_q[ptr_q][6:0], 1'b0};
              state_q  <= RD_DATA;
            end else begin
              sda_en_q <= 1'b0;
              state_q  <= PTR;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_en_q <= 1'b0;
            state_q  <= WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_rise && !byte_done) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (byte_done) begin
              bit_cnt_q <= '0;
              sda_en_q  <= 1'b0;
              state_q   <= RD_ACK;
            end else begin
              sda_en_q <= ~tx_q[7];
              tx_q     <= {tx_q[6:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            ptr_q <= ptr_inc;
            case (sda)
              I2cAck: begin
                tx_q    <= regs_q[ptr_inc];
                state_q <= RD_DATA;
              end
              I2cNack: state_q <= IDLE;
              default: state_q <= IDLE;
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else if (wr_fire) begin
      regs_q[ptr_q] <= rx_byte;
    end
  end

  for (genvar g = 0; g < NumRegs; g++) begin : g_flat
    assign regs_o[g*8 +: 8] = regs_q[g];
  end

  assign i2c_sda_o    = 1'b0;
  assign i2c_sda_en_o = sda_en_q;
  assign wr_pulse_o   = wr_fire;
  assign wr_idx_o     = ptr_q;

endmodule
